// File: rtl/trace_pkg.sv
// Shared types and decode constants for the retired-instruction trace buffer.
// Opcode/funct values mirror the core's instruction encoding header.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } trace_st_e;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  localparam int MNEM_CH = 8;
  typedef logic [8*MNEM_CH-1:0] mnem_t;

  localparam mnem_t S_NR  = mnem_t'("N-R");
  localparam mnem_t S_NOP = mnem_t'("NOP");

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  localparam logic [4:0] RS_MFC0    = 5'b00000;
  localparam logic [4:0] RS_MTC0    = 5'b00100;

endpackage

// File: rtl/mnem_dec.sv
// Combinational MIPS instruction to right-justified ASCII mnemonic decoder.
// Mnemonics longer than CHARS keep their rightmost characters.
module mnem_dec
  import trace_pkg::*;
#(
  parameter int CHARS = 6
) (
  input  logic [31:0]        instr,
  output logic [8*CHARS-1:0] ascii
);

  localparam int WW = (CHARS > MNEM_CH) ? CHARS : MNEM_CH;

  logic [5:0]      w_op;
  logic [5:0]      w_fn;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  mnem_t           w_m;
  mnem_t           w_sp;
  mnem_t           w_ri;
  logic [8*WW-1:0] w_wide;
  logic            w_unused_hi;

  assign w_op = instr[31:26];
  assign w_rs = instr[25:21];
  assign w_rt = instr[20:16];
  assign w_fn = instr[5:0];

  always_comb begin
    w_sp = S_NR;
    unique case (w_fn)
      FN_SLL:     w_sp = mnem_t'("SLL");
      FN_SRL:     w_sp = mnem_t'("SRL");
      FN_SRA:     w_sp = mnem_t'("SRA");
      FN_SLLV:    w_sp = mnem_t'("SLLV");
      FN_SRLV:    w_sp = mnem_t'("SRLV");
      FN_SRAV:    w_sp = mnem_t'("SRAV");
      FN_JR:      w_sp = mnem_t'("JR");
      FN_JALR:    w_sp = mnem_t'("JALR");
      FN_SYSCALL: w_sp = mnem_t'("SYSC");
      FN_BREAK:   w_sp = mnem_t'("BRE");
      FN_MFHI:    w_sp = mnem_t'("MFHI");
      FN_MTHI:    w_sp = mnem_t'("MTHI");
      FN_MFLO:    w_sp = mnem_t'("MFLO");
      FN_MTLO:    w_sp = mnem_t'("MTLO");
      FN_MULT:    w_sp = mnem_t'("MULT");
      FN_MULTU:   w_sp = mnem_t'("MULTU");
      FN_DIV:     w_sp = mnem_t'("DIV");
      FN_DIVU:    w_sp = mnem_t'("DIVU");
      FN_ADD:     w_sp = mnem_t'("ADD");
      FN_ADDU:    w_sp = mnem_t'("ADDU");
      FN_SUB:     w_sp = mnem_t'("SUB");
      FN_SUBU:    w_sp = mnem_t'("SUBU");
      FN_AND:     w_sp = mnem_t'("AND");
      FN_OR:      w_sp = mnem_t'("OR");
      FN_XOR:     w_sp = mnem_t'("XOR");
      FN_NOR:     w_sp = mnem_t'("NOR");
      FN_SLT:     w_sp = mnem_t'("SLT");
      FN_SLTU:    w_sp = mnem_t'("SLTU");
      default:    w_sp = S_NR;
    endcase
  end

  always_comb begin
    w_ri = S_NR;
    unique case (w_rt)
      RT_BLTZ:   w_ri = mnem_t'("BLTZ");
      RT_BGEZ:   w_ri = mnem_t'("BGEZ");
      RT_BLTZAL: w_ri = mnem_t'("BLTZAL");
      RT_BGEZAL: w_ri = mnem_t'("BGEZAL");
      default:   w_ri = S_NR;
    endcase
  end

  always_comb begin
    w_m = S_NR;
    if (instr == 32'd0) begin
      w_m = S_NOP;
    end else if (instr == ERET_WORD) begin
      w_m = mnem_t'("ERET");
    end else begin
      unique case (w_op)
        OP_SPECIAL: w_m = w_sp;
        OP_REGIMM:  w_m = w_ri;
        OP_COP0: begin
          if (w_rs == RS_MTC0)      w_m = mnem_t'("MTC0");
          else if (w_rs == RS_MFC0) w_m = mnem_t'("MFC0");
          else                      w_m = S_NR;
        end
        OP_J:       w_m = mnem_t'("J");
        OP_JAL:     w_m = mnem_t'("JAL");
        OP_BEQ:     w_m = mnem_t'("BEQ");
        OP_BNE:     w_m = mnem_t'("BNE");
        OP_BLEZ:    w_m = mnem_t'("BLEZ");
        OP_BGTZ:    w_m = mnem_t'("BGTZ");
        OP_ADDI:    w_m = mnem_t'("ADDI");
        OP_ADDIU:   w_m = mnem_t'("ADDIU");
        OP_SLTI:    w_m = mnem_t'("SLTI");
        OP_SLTIU:   w_m = mnem_t'("SLTIU");
        OP_ANDI:    w_m = mnem_t'("ANDI");
        OP_ORI:     w_m = mnem_t'("ORI");
        OP_XORI:    w_m = mnem_t'("XORI");
        OP_LUI:     w_m = mnem_t'("LUI");
        OP_LB:      w_m = mnem_t'("LB");
        OP_LH:      w_m = mnem_t'("LH");
        OP_LW:      w_m = mnem_t'("LW");
        OP_LBU:     w_m = mnem_t'("LBU");
        OP_LHU:     w_m = mnem_t'("LHU");
        OP_SB:      w_m = mnem_t'("SB");
        OP_SH:      w_m = mnem_t'("SH");
        OP_SW:      w_m = mnem_t'("SW");
        default:    w_m = S_NR;
      endcase
    end
  end

  // Slicing the low bytes of the right-justified string drops leading chars.
  assign w_wide      = (8*WW)'(w_m);
  assign ascii       = w_wide[8*CHARS-1:0];
  assign w_unused_hi = ^w_wide;

endmodule

// File: rtl/inst_trace_buf.sv
// Retired-instruction trace ring with PC-match trigger and freeze control.
// Two-stage capture (decode, write); registered read indexed from oldest.
module inst_trace_buf
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CHARS = 6,
  parameter int POST  = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     commit_valid,
  input  logic [PC_W-1:0]          commit_pc,
  input  logic [31:0]              commit_instr,
  input  logic                     trig_en,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic                     freeze_req,
  input  logic                     clear,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_pc,
  output logic [31:0]              rd_instr,
  output logic [8*CHARS-1:0]       rd_ascii,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wrapped,
  output logic [1:0]               state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] POST_C  = CW'(POST);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  trace_st_e          r_state;
  trace_st_e          w_state_n;

  logic               r_s1_valid;
  logic               r_s1_trig;
  logic [PC_W-1:0]    r_s1_pc;
  logic [31:0]        r_s1_instr;
  logic [8*CHARS-1:0] r_s1_ascii;
  logic [8*CHARS-1:0] w_ascii;

  logic [AW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic               r_wrapped;
  logic [CW-1:0]      r_post_cnt;
  logic [CW-1:0]      r_cap_left;

  logic [PC_W-1:0]    r_mem_pc    [0:DEPTH-1];
  logic [31:0]        r_mem_instr [0:DEPTH-1];
  logic [8*CHARS-1:0] r_mem_ascii [0:DEPTH-1];

  logic               r_rd_valid;
  logic [PC_W-1:0]    r_rd_pc;
  logic [31:0]        r_rd_instr;
  logic [8*CHARS-1:0] r_rd_ascii;

  logic               w_hit;
  logic               w_cap;
  logic               w_trig;
  logic               w_wr;
  logic               w_post_dec;
  logic               w_fin;
  logic [AW-1:0]      w_rd_base;
  logic [AW-1:0]      w_rd_addr;
  logic               w_rd_ok;

  mnem_dec #(
    .CHARS (CHARS)
  ) u_dec (
    .instr (commit_instr),
    .ascii (w_ascii)
  );

  assign w_hit = commit_valid && trig_en && (commit_pc == trig_pc);

  // In POST, stop taking commits once the post-trigger quota is in flight.
  always_comb begin
    w_cap  = 1'b0;
    w_trig = 1'b0;
    if (commit_valid && !clear && !freeze_req) begin
      case (r_state)
        ST_ARMED: begin
          w_cap  = 1'b1;
          w_trig = w_hit;
        end
        ST_POST:  w_cap = (r_cap_left != '0);
        default:  w_cap = 1'b0;
      endcase
    end
  end

  assign w_wr       = r_s1_valid && !clear;
  assign w_post_dec = (r_state == ST_POST) && r_s1_valid && !r_s1_trig;
  assign w_fin      = r_s1_valid &&
                      (r_s1_trig ? (POST_C == '0) : (r_post_cnt == ONE_C));

  always_comb begin
    w_state_n = r_state;
    if (clear) begin
      w_state_n = ST_ARMED;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (freeze_req) w_state_n = ST_FROZEN;
          else if (w_hit) w_state_n = ST_POST;
        end
        ST_POST: begin
          if (freeze_req || w_fin) w_state_n = ST_FROZEN;
        end
        default: w_state_n = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_ARMED;
    else         r_state <= w_state_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_post_cnt <= '0;
      r_cap_left <= '0;
    end else if (clear) begin
      r_post_cnt <= '0;
      r_cap_left <= '0;
    end else if (w_trig) begin
      r_post_cnt <= POST_C;
      r_cap_left <= POST_C;
    end else begin
      if (w_post_dec && r_post_cnt != '0)
        r_post_cnt <= r_post_cnt - ONE_C;
      if (r_state == ST_POST && w_cap)
        r_cap_left <= r_cap_left - ONE_C;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_trig  <= 1'b0;
      r_s1_pc    <= '0;
      r_s1_instr <= '0;
      r_s1_ascii <= '0;
    end else if (clear) begin
      r_s1_valid <= 1'b0;
      r_s1_trig  <= 1'b0;
    end else begin
      r_s1_valid <= w_cap;
      if (w_cap) begin
        r_s1_trig  <= w_trig;
        r_s1_pc    <= commit_pc;
        r_s1_instr <= commit_instr;
        r_s1_ascii <= w_ascii;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (clear) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (r_s1_valid) begin
      r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (r_count == DEPTH_C) r_wrapped <= 1'b1;
      else                    r_count   <= r_count + ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_pc[r_wr_ptr]    <= r_s1_pc;
      r_mem_instr[r_wr_ptr] <= r_s1_instr;
      r_mem_ascii[r_wr_ptr] <= r_s1_ascii;
    end
  end

  // Once wrapped, the write pointer marks the oldest surviving entry.
  assign w_rd_base = r_wrapped ? r_wr_ptr : '0;
  assign w_rd_addr = w_rd_base + rd_idx;
  assign w_rd_ok   = ({1'b0, rd_idx} < r_count);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_valid <= 1'b0;
      r_rd_pc    <= '0;
      r_rd_instr <= '0;
      r_rd_ascii <= '0;
    end else if (clear) begin
      r_rd_valid <= 1'b0;
      r_rd_pc    <= '0;
      r_rd_instr <= '0;
      r_rd_ascii <= '0;
    end else begin
      r_rd_valid <= w_rd_ok;
      r_rd_pc    <= w_rd_ok ? r_mem_pc[w_rd_addr]    : '0;
      r_rd_instr <= w_rd_ok ? r_mem_instr[w_rd_addr] : '0;
      r_rd_ascii <= w_rd_ok ? r_mem_ascii[w_rd_addr] : '0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_pc    = r_rd_pc;
  assign rd_instr = r_rd_instr;
  assign rd_ascii = r_rd_ascii;
  assign count    = r_count;
  assign wrapped  = r_wrapped;
  assign state_o  = r_state;

endmodule

// File: tb/tb_inst_trace_buf.sv
// Scoreboard bench for inst_trace_buf (DEPTH=4, POST=2, CHARS=6).
// Read expectations are queued at drive time and popped on the result cycle.
module tb_inst_trace_buf;

  localparam int DEPTH = 4;
  localparam int CHARS = 6;
  localparam int POST  = 2;
  localparam int PC_W  = 32;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic                     commit_valid;
  logic [PC_W-1:0]          commit_pc;
  logic [31:0]              commit_instr;
  logic                     trig_en;
  logic [PC_W-1:0]          trig_pc;
  logic                     freeze_req;
  logic                     clear;
  logic [$clog2(DEPTH)-1:0] rd_idx;
  logic                     rd_valid;
  logic [PC_W-1:0]          rd_pc;
  logic [31:0]              rd_instr;
  logic [8*CHARS-1:0]       rd_ascii;
  logic [$clog2(DEPTH):0]   count;
  logic                     wrapped;
  logic [1:0]               state_o;

  inst_trace_buf #(
    .DEPTH (DEPTH),
    .CHARS (CHARS),
    .POST  (POST),
    .PC_W  (PC_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_instr (commit_instr),
    .trig_en      (trig_en),
    .trig_pc      (trig_pc),
    .freeze_req   (freeze_req),
    .clear        (clear),
    .rd_idx       (rd_idx),
    .rd_valid     (rd_valid),
    .rd_pc        (rd_pc),
    .rd_instr     (rd_instr),
    .rd_ascii     (rd_ascii),
    .count        (count),
    .wrapped      (wrapped),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [47:0] asc;
  } rd_exp_t;

  rd_exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] asc(input string s);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r = {r[39:0], 8'(s[i])};
    return r;
  endfunction

  task automatic commit(input logic [31:0] pc, input logic [31:0] ins,
                        input logic frz);
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_instr = ins;
    freeze_req   = frz;
    @(negedge clk);
    commit_valid = 1'b0;
    freeze_req   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic rd(input int idx, input logic v, input logic [31:0] pc,
                    input logic [31:0] ins, input string s);
    rd_exp_t e;
    rd_exp_t g;
    e.v   = v;
    e.pc  = v ? pc : 32'd0;
    e.ins = v ? ins : 32'd0;
    e.asc = v ? asc(s) : 48'd0;
    rd_idx = 2'(idx);
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    check($sformatf("rd%0d_valid", idx), 64'(rd_valid), 64'(g.v));
    check($sformatf("rd%0d_pc", idx), 64'(rd_pc), 64'(g.pc));
    check($sformatf("rd%0d_instr", idx), 64'(rd_instr), 64'(g.ins));
    check($sformatf("rd%0d_ascii", idx), 64'(rd_ascii), 64'(g.asc));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetn       = 1'b0;
    commit_valid = 1'b0;
    commit_pc    = '0;
    commit_instr = '0;
    trig_en      = 1'b0;
    trig_pc      = '0;
    freeze_req   = 1'b0;
    clear        = 1'b0;
    rd_idx       = '0;
    idle(2);
    check("rst_state", 64'(state_o), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_wrapped", 64'(wrapped), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    resetn = 1'b1;
    idle(1);

    // Decode and latency: not readable one cycle after commit, then readable.
    commit(32'h10, 32'h0000_0000, 1'b0);
    rd(0, 1'b0, 32'h0, 32'h0, "");
    rd(0, 1'b1, 32'h10, 32'h0000_0000, "NOP");
    commit(32'h14, 32'h0232_8020, 1'b0);
    commit(32'h18, 32'h4200_0018, 1'b0);
    commit(32'h1C, 32'hFC00_0000, 1'b0);
    idle(1);
    check("dec_count", 64'(count), 64'(4));
    check("dec_wrapped", 64'(wrapped), 64'(0));
    rd(0, 1'b1, 32'h10, 32'h0000_0000, "NOP");
    rd(1, 1'b1, 32'h14, 32'h0232_8020, "ADD");
    rd(2, 1'b1, 32'h18, 32'h4200_0018, "ERET");
    rd(3, 1'b1, 32'h1C, 32'hFC00_0000, "N-R");

    // Wrap-around: six entries into a four-deep ring.
    do_clear();
    check("clr_count", 64'(count), 64'(0));
    commit(32'h100, 32'h2401_0001, 1'b0);
    commit(32'h104, 32'h8C22_0000, 1'b0);
    commit(32'h108, 32'hAC22_0000, 1'b0);
    commit(32'h10C, 32'h0410_0000, 1'b0);
    commit(32'h110, 32'h0000_000C, 1'b0);
    commit(32'h114, 32'h4002_6000, 1'b0);
    idle(1);
    check("wrap_count", 64'(count), 64'(4));
    check("wrap_flag", 64'(wrapped), 64'(1));
    rd(0, 1'b1, 32'h108, 32'hAC22_0000, "SW");
    rd(1, 1'b1, 32'h10C, 32'h0410_0000, "BLTZAL");
    rd(2, 1'b1, 32'h110, 32'h0000_000C, "SYSC");
    rd(3, 1'b1, 32'h114, 32'h4002_6000, "MFC0");

    // PC trigger with two post-trigger entries.
    do_clear();
    trig_en = 1'b1;
    trig_pc = 32'h200;
    for (int i = 0; i < 9; i++) begin
      logic [31:0] pc;
      pc = 32'h1F8 + 32'(4 * i);
      commit(pc, 32'h0022_1021, 1'b0);
      if (pc == 32'h200) check("trig_post", 64'(state_o), 64'(1));
    end
    idle(1);
    check("trig_frozen", 64'(state_o), 64'(2));
    check("trig_count", 64'(count), 64'(4));
    check("trig_wrapped", 64'(wrapped), 64'(1));
    rd(0, 1'b1, 32'h1FC, 32'h0022_1021, "ADDU");
    rd(1, 1'b1, 32'h200, 32'h0022_1021, "ADDU");
    rd(3, 1'b1, 32'h208, 32'h0022_1021, "ADDU");
    commit(32'h21C, 32'h0000_000D, 1'b0);
    commit(32'h220, 32'h0000_000D, 1'b0);
    idle(1);
    rd(3, 1'b1, 32'h208, 32'h0022_1021, "ADDU");
    check("frz_state", 64'(state_o), 64'(2));
    trig_en = 1'b0;

    // Clear from FROZEN; same-cycle commit is discarded.
    commit_valid = 1'b1;
    commit_pc    = 32'h3F0;
    commit_instr = 32'h0000_0000;
    clear        = 1'b1;
    @(negedge clk);
    commit_valid = 1'b0;
    clear        = 1'b0;
    check("clr_state", 64'(state_o), 64'(0));
    check("clr_wrapped", 64'(wrapped), 64'(0));
    commit(32'h400, 32'h4080_0000, 1'b0);
    commit(32'h404, 32'h4040_0000, 1'b0);
    idle(1);
    check("re_count", 64'(count), 64'(2));
    check("re_wrapped", 64'(wrapped), 64'(0));
    check("re_state", 64'(state_o), 64'(0));
    rd(0, 1'b1, 32'h400, 32'h4080_0000, "MTC0");
    rd(1, 1'b1, 32'h404, 32'h4040_0000, "N-R");

    // freeze_req blocks its own commit but not the entry in stage 1.
    do_clear();
    commit(32'h2F8, 32'h0000_000D, 1'b0);
    commit(32'h2FC, 32'h0410_0000, 1'b0);
    commit(32'h300, 32'h0232_8020, 1'b1);
    commit(32'h304, 32'h0232_8020, 1'b0);
    idle(1);
    check("fz_count", 64'(count), 64'(2));
    check("fz_state", 64'(state_o), 64'(2));
    rd(0, 1'b1, 32'h2F8, 32'h0000_000D, "BRE");
    rd(2, 1'b0, 32'h0, 32'h0, "");
    rd(1, 1'b1, 32'h2FC, 32'h0410_0000, "BLTZAL");

    // Asynchronous reset between clock edges.
    #2;
    resetn = 1'b0;
    #1;
    check("ar_rd_valid", 64'(rd_valid), 64'(0));
    check("ar_rd_pc", 64'(rd_pc), 64'(0));
    check("ar_rd_instr", 64'(rd_instr), 64'(0));
    check("ar_rd_ascii", 64'(rd_ascii), 64'(0));
    check("ar_count", 64'(count), 64'(0));
    check("ar_state", 64'(state_o), 64'(0));
    check("ar_wrapped", 64'(wrapped), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    rd(0, 1'b0, 32'h0, 32'h0, "");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/inst_trace_buf.md
Name: inst_trace_buf

Overview:
Debug-only retired-instruction trace buffer for the MIPS core. Each committed instruction is decoded to an ASCII mnemonic and stored with its PC and raw word in a circular history of DEPTH entries. A PC-match trigger or an external freeze stops capture after a programmable number of post-trigger entries. The buffer sits beside the writeback stage, and its contents are read back by simulation benches or an ILA.

Parameters:
DEPTH, 16, number of history entries; power of two, at least 2.
CHARS, 6, mnemonic width in ASCII characters; ascii buses are 8*CHARS bits.
POST, 4, entries captured after the trigger entry before freezing; range 0..DEPTH-1.
PC_W, 32, PC width.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
commit_valid  in  1  instruction retires this cycle
commit_pc  in  PC_W  PC of the retiring instruction
commit_instr  in  32  raw instruction word
trig_en  in  1  enable the PC-match trigger
trig_pc  in  PC_W  trigger PC
freeze_req  in  1  pulse: freeze immediately
clear  in  1  pulse: empty the buffer and re-arm
rd_idx  in  $clog2(DEPTH)  read index; 0 is the oldest entry
rd_valid  out  1  rd_idx < count (registered)
rd_pc  out  PC_W  stored PC
rd_instr  out  32  stored instruction word
rd_ascii  out  8*CHARS  stored mnemonic
count  out  $clog2(DEPTH)+1  valid entries; saturates at DEPTH
wrapped  out  1  at least one entry has been overwritten
state_o  out  2  0=ARMED 1=POST 2=FROZEN

Behaviour:
- Reset, also applied by clear: all outputs 0, pointers 0, pipeline valid 0, state ARMED. Memory contents need not be reset.
- Clock and reset: one clock, clk. resetn is asynchronous and active-low.
- Stage 1: if commit_valid and state != FROZEN, register pc, instr, the decoded mnemonic and s1_valid.
- Stage 2: if s1_valid, write mem[wr_ptr] and advance wr_ptr modulo DEPTH.
  - count increments and saturates at DEPTH.
  - On a write when count == DEPTH, set wrapped (sticky until clear).
  - Commit-to-readable latency is 2 cycles.
- Mnemonic encoding:
  - Right-justified; unused high bytes are 8'h00.
  - A mnemonic longer than CHARS keeps its rightmost CHARS characters.
- Decode rules, in priority order:
  - instr == 0 gives "NOP".
  - instr == 32'h42000018 gives "ERET".
  - Opcode 0: decode by funct. Opcode 1 (REGIMM): decode by rt. Opcode 16 (COP0): rs 00100 gives "MTC0", rs 00000 gives "MFC0".
  - All other opcodes decode by opcode, using the same mnemonic set as the existing debug decoder; SYSCALL is "SYSC", BREAK is "BRE".
  - Any unmatched encoding, including COP0 with another rs, gives "N-R".
- State machine:
  - ARMED: if commit_valid & trig_en & commit_pc == trig_pc, go to POST with post_cnt = POST. The trigger instruction itself is captured.
  - POST: each stage-2 write after the trigger entry decrements post_cnt. When POST == 0, go to FROZEN on the cycle the trigger entry is written. Otherwise go to FROZEN on the write that takes post_cnt to 0.
  - FROZEN: no new stage-1 captures. An entry already in stage 1 is still written. Leave only via clear or reset.
  - freeze_req in ARMED or POST goes to FROZEN next cycle and blocks a same-cycle commit.
  - A trigger match while in POST is ignored.
- Priority: reset, then clear, then freeze_req, then trigger. clear in the same cycle as commit_valid discards that commit.
- Read path:
  - Registered, 1-cycle latency.
  - Physical address = (wrapped ? wr_ptr : 0) + rd_idx, modulo DEPTH.
  - rd_idx >= count gives rd_valid = 0 and zero data.
  - Reads are allowed in any state. A read and a write to the same slot in one cycle returns the old data.

Decomposition:
- Shared package trace_pkg:
  - state encodings ARMED/POST/FROZEN;
  - ERET_WORD constant;
  - the "N-R" and "NOP" strings;
  - opcode and funct constants, taken from the existing defines header.
- One sub-module, mnem_dec: combinational, parametrised by CHARS, instr in and ascii out, implementing the decode rules.
- The ring memory and the state machine stay in the top module.

Test Plan:
- Commit 32'h00000000, then 32'h02328020, then 32'h42000018, then 32'hFC000000 → entries 0..3 read "NOP", "ADD", "ERET", "N-R"; count = 4; each entry readable 2 cycles after its commit.
- DEPTH=4, commit PCs 0x100..0x114 (six entries) → count = 4, wrapped = 1, rd_idx 0..3 return 0x108, 0x10C, 0x110, 0x114.
- POST=2, trig_pc = 0x200, commit PCs 0x1F8..0x218 → last captured entry 0x208, state_o = 2, count stays constant afterwards.
- freeze_req in the same cycle as commit_valid (PC 0x300), with 0x2FC in stage 1 → 0x2FC is stored, 0x300 is not.
- clear while in FROZEN, then one commit at PC 0x400 → count = 1, wrapped = 0, state ARMED, rd_idx 0 returns 0x400.
- resetn low mid-capture (asynchronous, between clock edges) → all outputs 0 immediately; rd_idx 0 gives rd_valid = 0.
